// File: rtl/uno_draw_scheduler.sv
// uno_draw_scheduler
// ------------------
// Shares the UNO deck engine between the game controller and the players.
// A new game triggers the deck shuffle. The block then deals DEAL_CARDS cards
// to every player, round-robin. After the deal it serves per-player draw
// requests of 1..4 cards in round-robin order. Each card is pulled from the
// deck through a single-card draw handshake.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_new_game        1-cycle pulse; accepted only in IDLE or ARB
//   i_req             per-player draw request (level, held until o_ack)
//   i_req_cnt         per-player card count, player p at [3p+2:3p]
//   o_ack             1-cycle pulse when a player's request is complete
//   o_deck_start      1-cycle shuffle start to the deck
//   o_deck_draw       draw command to the deck (3'b001 while fetching)
//   i_deck_done       deck idle/ready
//   i_deck_drawn      deck presents a card on i_deck_card this cycle
//   i_deck_card       {color[1:0], value[3:0]}
//   o_card_valid      1-cycle pulse, o_card / o_card_player valid
//   o_card            last delivered card (held between pulses)
//   o_card_player     receiving player of o_card
//   o_dealing         high from shuffle start until the deal completes
//   o_busy            high in every state except IDLE and ARB
//   o_error           sticky deck timeout flag
module uno_draw_scheduler #(
  parameter int N_PLAYERS  = 4,
  parameter int DEAL_CARDS = 7,
  parameter int TIMEOUT    = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_new_game,
  input  logic [N_PLAYERS-1:0]         i_req,
  input  logic [3*N_PLAYERS-1:0]       i_req_cnt,
  output logic [N_PLAYERS-1:0]         o_ack,
  output logic                         o_deck_start,
  output logic [2:0]                   o_deck_draw,
  input  logic                         i_deck_done,
  input  logic                         i_deck_drawn,
  input  logic [5:0]                   i_deck_card,
  output logic                         o_card_valid,
  output logic [5:0]                   o_card,
  output logic [$clog2(N_PLAYERS)-1:0] o_card_player,
  output logic                         o_dealing,
  output logic                         o_busy,
  output logic                         o_error
);

  localparam int PW = $clog2(N_PLAYERS);
  localparam int RW = $clog2(DEAL_CARDS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHUF,
    S_SHUF_DLY,
    S_SHUF_WAIT,
    S_FETCH,
    S_WAIT_DONE,
    S_ARB,
    S_ACK
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_gnt;
  logic [PW-1:0]         r_player;
  logic [RW-1:0]         r_round;
  logic [2:0]            r_rem;
  logic [TW-1:0]         r_tmo;
  logic [N_PLAYERS-1:0]  r_ack;
  logic                  r_start;
  logic                  r_draw;
  logic                  r_card_valid;
  logic [5:0]            r_card;
  logic [PW-1:0]         r_card_player;
  logic                  r_dealing;
  logic                  r_error;

  logic [2:0]            w_cnt [N_PLAYERS];
  logic                  w_gnt_vld;
  logic [PW-1:0]         w_gnt_idx;
  logic [2:0]            w_gnt_raw;
  logic [2:0]            w_gnt_cnt;
  logic [PW:0]           w_sum;
  logic [PW-1:0]         w_idx;
  logic [PW-1:0]         w_ptr_nxt;
  logic [PW-1:0]         w_player_nxt;
  logic                  w_player_wrap;
  logic                  w_tmo_hit;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_cnt
    assign w_cnt[p] = i_req_cnt[3*p +: 3];
  end

  // Round-robin scan starting at r_ptr; the first requester found wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_gnt_raw = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N_PLAYERS)) begin
        w_sum = w_sum - (PW+1)'(N_PLAYERS);
      end
      w_idx = w_sum[PW-1:0];
      if (!w_gnt_vld && i_req[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
        w_gnt_raw = w_cnt[w_idx];
      end
    end
  end

  // Requests larger than four cards are served as four.
  assign w_gnt_cnt     = (w_gnt_raw > 3'd4) ? 3'd4 : w_gnt_raw;
  assign w_ptr_nxt     = (w_gnt_idx == PW'(N_PLAYERS - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_player_wrap = (r_player == PW'(N_PLAYERS - 1));
  assign w_player_nxt  = w_player_wrap ? '0 : r_player + 1'b1;
  assign w_tmo_hit     = (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_gnt         <= '0;
      r_player      <= '0;
      r_round       <= '0;
      r_rem         <= '0;
      r_tmo         <= '0;
      r_ack         <= '0;
      r_start       <= 1'b0;
      r_draw        <= 1'b0;
      r_card_valid  <= 1'b0;
      r_card        <= '0;
      r_card_player <= '0;
      r_dealing     <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      r_start      <= 1'b0;
      r_card_valid <= 1'b0;
      r_ack        <= '0;

      case (r_state)
        S_IDLE: begin
          if (i_new_game) begin
            r_state   <= S_SHUF;
            r_start   <= 1'b1;
            r_dealing <= 1'b1;
            r_error   <= 1'b0;
            r_player  <= '0;
            r_round   <= '0;
          end
        end

        // Shuffle start cycle; deck done is not trusted until two cycles later.
        S_SHUF: begin
          r_state <= S_SHUF_DLY;
        end

        S_SHUF_DLY: begin
          r_state <= S_SHUF_WAIT;
          r_tmo   <= '0;
        end

        S_SHUF_WAIT: begin
          if (i_deck_done) begin
            r_player <= '0;
            r_round  <= '0;
            r_draw   <= 1'b1;
            r_tmo    <= '0;
            r_state  <= S_FETCH;
          end else if (w_tmo_hit) begin
            r_error   <= 1'b1;
            r_draw    <= 1'b0;
            r_dealing <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        // r_dealing selects the return target: deal advance or play advance.
        S_FETCH: begin
          if (i_deck_drawn) begin
            r_card        <= i_deck_card;
            r_card_valid  <= 1'b1;
            r_card_player <= r_dealing ? r_player : r_gnt;
            r_draw        <= 1'b0;
            r_tmo         <= '0;
            r_state       <= S_WAIT_DONE;
          end else if (w_tmo_hit) begin
            r_error   <= 1'b1;
            r_draw    <= 1'b0;
            r_dealing <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (i_deck_done) begin
            r_tmo <= '0;
            if (r_dealing) begin
              r_player <= w_player_nxt;
              if (w_player_wrap) begin
                r_round <= r_round + 1'b1;
              end
              if (w_player_wrap && (r_round == RW'(DEAL_CARDS - 1))) begin
                r_dealing <= 1'b0;
                r_state   <= S_ARB;
              end else begin
                r_draw  <= 1'b1;
                r_state <= S_FETCH;
              end
            end else begin
              r_rem <= r_rem - 1'b1;
              if (r_rem == 3'd1) begin
                r_ack[r_gnt] <= 1'b1;
                r_state      <= S_ACK;
              end else begin
                r_draw  <= 1'b1;
                r_state <= S_FETCH;
              end
            end
          end else if (w_tmo_hit) begin
            r_error   <= 1'b1;
            r_draw    <= 1'b0;
            r_dealing <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        // A new game outranks any pending request.
        S_ARB: begin
          if (i_new_game) begin
            r_state   <= S_SHUF;
            r_start   <= 1'b1;
            r_dealing <= 1'b1;
            r_error   <= 1'b0;
            r_player  <= '0;
            r_round   <= '0;
          end else if (w_gnt_vld) begin
            r_gnt <= w_gnt_idx;
            r_ptr <= w_ptr_nxt;
            r_rem <= w_gnt_cnt;
            if (w_gnt_cnt == 3'd0) begin
              r_ack[w_gnt_idx] <= 1'b1;
              r_state          <= S_ACK;
            end else begin
              r_draw  <= 1'b1;
              r_tmo   <= '0;
              r_state <= S_FETCH;
            end
          end
        end

        // Ack cycle: keeps the just-served request from being re-granted
        // before the requester has seen its ack.
        S_ACK: begin
          r_state <= S_ARB;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack         = r_ack;
  assign o_deck_start  = r_start;
  assign o_deck_draw   = {2'b00, r_draw};
  assign o_card_valid  = r_card_valid;
  assign o_card        = r_card;
  assign o_card_player = r_card_player;
  assign o_dealing     = r_dealing;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_ARB);
  assign o_error       = r_error;

endmodule
